// File: rtl/delay_sched_pkg.sv
// Shared types and constants for the delay scheduler.
package delay_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RWAIT = 2'd1,
      WAIT5 = 2'd2
   } state_t;

   // 12-bit Fibonacci LFSR, x^12+x^6+x^4+x+1, shifting left.
   localparam logic [11:0] LFSR_SEED = 12'hACE;
   localparam logic [11:0] LFSR_TAPS = 12'h829;   // bits 11, 5, 3, 0

   localparam logic [13:0] MAX_MS   = 14'd9999;
   localparam int unsigned MS_PER_S = 1000;

   // Width of the countdown ms counter.
   localparam int unsigned CD_W = 16;

   function automatic logic [11:0] lfsr_next(input logic [11:0] v);
      return {v[10:0], ^(v & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick every CYCLES enabled cycles.
// clr restarts the phase and wins over en; the phase holds while en is low.
module ms_tick_gen #(
   parameter int unsigned CYCLES = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);

   logic [31:0] cnt;
   logic        at_end;

   assign at_end = (cnt == CYCLES - 1);
   assign tick   = en & ~clr & at_end;

   // Phase counter, wraps at CYCLES-1.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= at_end ? '0 : cnt + 1;
      end
   end

endmodule

// File: rtl/delay_sched.sv
// Delay scheduler: random wait / fixed delay countdowns plus a reaction-time
// counter in ms. Optional macro DELAY_SCHED_RANDOM_EN selects an LFSR-derived
// random-wait length; without it the random wait is RWAIT_MIN_MS+1024 ms.
module delay_sched
   import delay_sched_pkg::*;
#(
   parameter int unsigned CLK_HZ       = 100_000_000,
   parameter int unsigned LATE_MS      = 1000,
   parameter int unsigned WAIT5_MS     = 5000,
   parameter int unsigned RWAIT_MIN_MS = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_rwait,
   input  logic        start_wait5,
   input  logic        time_clr,
   input  logic        time_en,
   output logic        rwait_done,
   output logic        wait5_done,
   output logic        time_late,
   output logic [13:0] reaction_ms,
   output logic        busy
);

   localparam int unsigned     CYC_PER_MS = CLK_HZ / MS_PER_S;
   localparam logic [CD_W-1:0] WAIT5_LD   = CD_W'(WAIT5_MS);
   localparam logic [13:0]     LATE_TH    = 14'(LATE_MS);

   state_t          state, state_n;
   logic [CD_W-1:0] ms_left, ms_left_n;
   logic [CD_W-1:0] rwait_len;
   logic            rw_q, w5_q;
   logic            rw_rise, w5_rise;
   logic            cd_clr, cd_tick;
   logic            rt_tick;

   assign rw_rise   = start_rwait & ~rw_q;
   assign w5_rise   = start_wait5 & ~w5_q;
   assign busy      = (state != IDLE);
   assign time_late = (reaction_ms >= LATE_TH);

`ifdef DELAY_SCHED_RANDOM_EN
   logic [11:0] lfsr;

   // Free-running LFSR, reseeded by reset.
   always_ff @(posedge clk) begin
      if (rst) lfsr <= LFSR_SEED;
      else     lfsr <= lfsr_next(lfsr);
   end

   assign rwait_len = CD_W'(RWAIT_MIN_MS) + CD_W'(lfsr[10:0]);
`else
   assign rwait_len = CD_W'(RWAIT_MIN_MS + 1024);
`endif

   ms_tick_gen #(.CYCLES(CYC_PER_MS)) u_cd_tick (
      .clk  (clk),
      .rst  (rst),
      .clr  (cd_clr),
      .en   (busy),
      .tick (cd_tick)
   );

   ms_tick_gen #(.CYCLES(CYC_PER_MS)) u_rt_tick (
      .clk  (clk),
      .rst  (rst),
      .clr  (time_clr),
      .en   (time_en),
      .tick (rt_tick)
   );

   // Countdown state, remaining ms and request-edge history.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         ms_left <= '0;
         rw_q    <= 1'b0;
         w5_q    <= 1'b0;
      end else begin
         state   <= state_n;
         ms_left <= ms_left_n;
         rw_q    <= start_rwait;
         w5_q    <= start_wait5;
      end
   end

   // Next-state, duration load and done pulses; a zero length counts as 1 ms.
   always_comb begin
      state_n    = state;
      ms_left_n  = ms_left;
      cd_clr     = 1'b0;
      rwait_done = 1'b0;
      wait5_done = 1'b0;
      case (state)
         IDLE: begin
            if (rw_rise) begin
               state_n   = RWAIT;
               ms_left_n = rwait_len;
               cd_clr    = 1'b1;
            end else if (w5_rise) begin
               state_n   = WAIT5;
               ms_left_n = WAIT5_LD;
               cd_clr    = 1'b1;
            end
         end
         RWAIT: begin
            if (cd_tick) begin
               if (ms_left <= CD_W'(1)) begin
                  state_n    = IDLE;
                  rwait_done = 1'b1;
               end else begin
                  ms_left_n = ms_left - CD_W'(1);
               end
            end
         end
         WAIT5: begin
            // A random-wait request preempts the fixed delay, even on its last tick.
            if (rw_rise) begin
               state_n   = RWAIT;
               ms_left_n = rwait_len;
               cd_clr    = 1'b1;
            end else if (cd_tick) begin
               if (ms_left <= CD_W'(1)) begin
                  state_n    = IDLE;
                  wait5_done = 1'b1;
               end else begin
                  ms_left_n = ms_left - CD_W'(1);
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Reaction counter in ms, saturating at MAX_MS.
   always_ff @(posedge clk) begin
      if (rst || time_clr) begin
         reaction_ms <= '0;
      end else if (rt_tick && (reaction_ms != MAX_MS)) begin
         reaction_ms <= reaction_ms + 14'd1;
      end
   end

endmodule

// File: tb/tb_delay_sched.sv
// Self-checking bench for delay_sched (default build, random length disabled).
// Main instance: 5 cycles/ms with shortened ms parameters; second instance at
// 2 cycles/ms exercises reaction-counter saturation.
module tb_delay_sched;

   localparam int CPM  = 5;
   localparam int D_RW = (100 + 1024) * CPM;   // 5620 cycles
   localparam int D_W5 = 500 * CPM;            // 2500 cycles

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_rwait = 1'b0, start_wait5 = 1'b0;
   logic        time_clr = 1'b0, time_en = 1'b0;
   logic        rwait_done, wait5_done, time_late, busy;
   logic [13:0] reaction_ms;

   logic        r2_clr = 1'b0, r2_en = 1'b0;
   logic        r2_rwait_done, r2_wait5_done, r2_late, r2_busy;
   logic [13:0] r2_ms;

   int errors = 0;
   int checks = 0;
   int edge_n = 0;
   int rw_cnt = 0, w5_cnt = 0, busy_cnt = 0, rw_cyc = 0, w5_cyc = 0;

   typedef struct {
      logic        clr;
      logic        en;
      int          cycles;
      logic [13:0] exp_ms;
      logic        exp_late;
   } vec_t;

   vec_t vt[12];

   delay_sched #(
      .CLK_HZ       (5000),
      .LATE_MS      (100),
      .WAIT5_MS     (500),
      .RWAIT_MIN_MS (100)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start_rwait (start_rwait),
      .start_wait5 (start_wait5),
      .time_clr    (time_clr),
      .time_en     (time_en),
      .rwait_done  (rwait_done),
      .wait5_done  (wait5_done),
      .time_late   (time_late),
      .reaction_ms (reaction_ms),
      .busy        (busy)
   );

   delay_sched #(
      .CLK_HZ (2000)
   ) dut2 (
      .clk         (clk),
      .rst         (rst),
      .start_rwait (1'b0),
      .start_wait5 (1'b0),
      .time_clr    (r2_clr),
      .time_en     (r2_en),
      .rwait_done  (r2_rwait_done),
      .wait5_done  (r2_wait5_done),
      .time_late   (r2_late),
      .reaction_ms (r2_ms),
      .busy        (r2_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_n <= edge_n + 1;

   // Pulse and busy monitor; cycle index is the edge that ends the sampled cycle.
   always @(negedge clk) begin
      if (rwait_done) begin
         rw_cnt = rw_cnt + 1;
         rw_cyc = edge_n + 1;
      end
      if (wait5_done) begin
         w5_cnt = w5_cnt + 1;
         w5_cyc = edge_n + 1;
      end
      if (busy) busy_cnt = busy_cnt + 1;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_rw(input int base, input int budget, input string name);
      int n;
      n = 0;
      while (rw_cnt == base && n < budget) begin
         tick(1);
         n++;
      end
      chk({name, "_seen"}, (rw_cnt != base) ? 1 : 0, 1);
   endtask

   initial begin
      int n0, rb, wb, bb;

      vt[0]  = '{1'b1, 1'b0,   1, 14'd0,   1'b0};
      vt[1]  = '{1'b0, 1'b1, 499, 14'd99,  1'b0};
      vt[2]  = '{1'b0, 1'b1,   1, 14'd100, 1'b1};
      vt[3]  = '{1'b0, 1'b0,   3, 14'd100, 1'b1};
      vt[4]  = '{1'b0, 1'b1,   3, 14'd100, 1'b1};
      vt[5]  = '{1'b0, 1'b0,   7, 14'd100, 1'b1};
      vt[6]  = '{1'b0, 1'b1,   2, 14'd101, 1'b1};
      vt[7]  = '{1'b1, 1'b1,   4, 14'd0,   1'b0};
      vt[8]  = '{1'b0, 1'b1,   4, 14'd0,   1'b0};
      vt[9]  = '{1'b0, 1'b1,   1, 14'd1,   1'b0};
      vt[10] = '{1'b0, 1'b1,  12, 14'd3,   1'b0};
      vt[11] = '{1'b1, 1'b0,   1, 14'd0,   1'b0};

      // Reset state
      tick(2);
      chk("reset_outs", int'({busy, rwait_done, wait5_done, time_late, reaction_ms}), 0);
      rst = 1'b0;
      tick(2);

      // Reaction counter vectors
      for (int i = 0; i < 12; i++) begin
         time_clr = vt[i].clr;
         time_en  = vt[i].en;
         tick(vt[i].cycles);
         chk($sformatf("vec%0d_ms", i), int'(reaction_ms), int'(vt[i].exp_ms));
         chk($sformatf("vec%0d_late", i), int'(time_late), int'(vt[i].exp_late));
      end
      time_clr = 1'b0;
      time_en  = 1'b0;
      tick(2);

      // Random wait: busy cycles N+1..N+D, done only in cycle N+D
      rb = rw_cnt; bb = busy_cnt;
      start_rwait = 1'b1;
      n0 = edge_n + 1;
      tick(1);
      chk("rw_busy_start", int'(busy), 1);
      wait_rw(rb, D_RW + 50, "rw");
      chk("rw_cycle", rw_cyc, n0 + D_RW);
      tick(20);
      chk("rw_pulses", rw_cnt - rb, 1);
      chk("rw_busy_cycles", busy_cnt - bb, D_RW);
      chk("rw_idle_after", int'(busy), 0);
      start_rwait = 1'b0;
      tick(2);

      // Fixed delay with request held high: one pulse, no restart
      wb = w5_cnt;
      start_wait5 = 1'b1;
      n0 = edge_n + 1;
      tick(6000);
      chk("w5_pulses", w5_cnt - wb, 1);
      chk("w5_cycle", w5_cyc, n0 + D_W5);
      chk("w5_idle_after", int'(busy), 0);
      start_wait5 = 1'b0;
      tick(2);

      // Preemption of a running fixed delay
      wb = w5_cnt; rb = rw_cnt;
      start_wait5 = 1'b1;
      tick(800);
      start_rwait = 1'b1;
      n0 = edge_n + 1;
      wait_rw(rb, D_RW + 50, "pre");
      chk("pre_rw_cycle", rw_cyc, n0 + D_RW);
      tick(20);
      chk("pre_no_w5", w5_cnt - wb, 0);
      start_wait5 = 1'b0;
      start_rwait = 1'b0;
      tick(2);

      // Simultaneous rises in IDLE: random wait wins, fixed delay discarded
      wb = w5_cnt; rb = rw_cnt;
      start_wait5 = 1'b1;
      start_rwait = 1'b1;
      n0 = edge_n + 1;
      wait_rw(rb, D_RW + 50, "sim");
      chk("sim_rw_cycle", rw_cyc, n0 + D_RW);
      tick(20);
      chk("sim_no_w5", w5_cnt - wb, 0);
      chk("sim_idle_after", int'(busy), 0);
      start_wait5 = 1'b0;
      start_rwait = 1'b0;
      tick(2);

      // Saturation at 9999 ms (2 cycles/ms instance)
      r2_clr = 1'b1;
      tick(1);
      r2_clr = 1'b0;
      r2_en  = 1'b1;
      tick(19996);
      chk("sat_9998", int'(r2_ms), 9998);
      tick(2);
      chk("sat_9999", int'(r2_ms), 9999);
      chk("sat_late", int'(r2_late), 1);
      tick(40);
      chk("sat_hold", int'(r2_ms), 9999);
      r2_en = 1'b0;

      // Reset mid-random-wait with the request held through reset release
      rb = rw_cnt;
      time_en = 1'b1;
      start_rwait = 1'b1;
      tick(2000);
      chk("rst_pre_busy", int'(busy), 1);
      rst = 1'b1;
      tick(1);
      chk("rst_outs", int'({busy, rwait_done, wait5_done, time_late, reaction_ms}), 0);
      time_en = 1'b0;
      tick(2);
      rst = 1'b0;
      n0 = edge_n + 1;
      wait_rw(rb, D_RW + 50, "rerq");
      chk("rerq_cycle", rw_cyc, n0 + D_RW);
      tick(20);
      chk("rerq_pulses", rw_cnt - rb, 1);
      start_rwait = 1'b0;
      tick(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
